// File: rtl/scan_pkg.sv
// Shared types and default constants for the scan sequencer.
// The DEAD state exists only when SCAN_SEQ_DEADTIME_EN is defined.
package scan_pkg;

  localparam int unsigned DIV_MAX_DEF  = 49999;
  localparam int unsigned DEAD_CYC_DEF = 8;

`ifdef SCAN_SEQ_DEADTIME_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/scan_prescaler.sv
// Dwell-time prescaler: counts 0..DIV_MAX and flags the terminal count.
// A clear holds the counter at zero.
module scan_prescaler #(
  parameter int unsigned DIV_MAX = 3,
  parameter int unsigned CNT_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DIV_MAX);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/scan_sequencer.sv
// Four-position multiplexed scan driver for an external 2:4 decoder.
// Optional per-position blanking is enabled by defining SCAN_SEQ_DEADTIME_EN.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DIV_MAX  = DIV_MAX_DEF,  // must be >= 1
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF  // 1..DIV_MAX-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] blank_mask,
  output logic       en_n,
  output logic       a,
  output logic       b,
  output logic       tick,
  output logic       frame_done
);

  // Sized to hold both counts so one width serves the prescaler and dead counter.
  localparam int unsigned CNT_MAX = (DIV_MAX > DEAD_CYC) ? DIV_MAX : DEAD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

`ifdef SCAN_SEQ_DEADTIME_EN
  localparam state_t           AFTER_TC  = DEAD;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  logic [CNT_W-1:0] dead_q, dead_d;
`else
  localparam state_t AFTER_TC = ON;
`endif

  state_t     state_q, state_d;
  logic [1:0] pos_q, pos_d;
  logic       en_n_d, tick_d, frame_done_d;
  logic       clear, tc;

  assign clear = !run || (state_q == IDLE);

  scan_prescaler #(
    .DIV_MAX (DIV_MAX),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tc    (tc)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    tick_d       = 1'b0;
    frame_done_d = 1'b0;
`ifdef SCAN_SEQ_DEADTIME_EN
    dead_d       = dead_q;
`endif
    if (!run) begin
      // Dropping run beats a coincident terminal count.
      state_d = IDLE;
      pos_d   = 2'd0;
`ifdef SCAN_SEQ_DEADTIME_EN
      dead_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = AFTER_TC;
`ifdef SCAN_SEQ_DEADTIME_EN
        DEAD: begin
          if (dead_q == DEAD_LAST) begin
            state_d = ON;
            dead_d  = '0;
          end else begin
            dead_d = dead_q + CNT_W'(1);
          end
        end
`endif
        ON:      state_d = ON;
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE && tc) begin
        pos_d        = pos_q + 2'd1;
        tick_d       = 1'b1;
        frame_done_d = (pos_q == 2'd3);
        state_d      = AFTER_TC;
`ifdef SCAN_SEQ_DEADTIME_EN
        dead_d       = '0;
`endif
      end
    end
    // Outputs are registered from next-state values so they line up with state.
    en_n_d = (state_d == ON) ? blank_mask[pos_d] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_q      <= 2'd0;
      en_n       <= 1'b1;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      en_n       <= en_n_d;
      tick       <= tick_d;
      frame_done <= frame_done_d;
    end
  end

`ifdef SCAN_SEQ_DEADTIME_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dead_q <= '0;
    end else begin
      dead_q <= dead_d;
    end
  end
`endif

  assign a = pos_q[1];
  assign b = pos_q[0];

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer (DIV_MAX=3, DEAD_CYC=1).
// The reference model tracks elapsed cycles since scan start and derives outputs arithmetically.
module tb_scan_sequencer;

  localparam int unsigned DIV_MAX  = 3;
  localparam int unsigned DEAD_CYC = 1;
  localparam int          PER      = DIV_MAX + 1;
`ifdef SCAN_SEQ_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] blank_mask;
  logic       en_n, a, b, tick, frame_done;

  int vectors    = 0;
  int miscompares = 0;
  int t          = -1;  // cycles since the scan left IDLE; -1 while idle
  bit found;

  scan_sequencer #(
    .DIV_MAX  (DIV_MAX),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .blank_mask (blank_mask),
    .en_n       (en_n),
    .a          (a),
    .b          (b),
    .tick       (tick),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected {en_n, a, b, tick, frame_done} for elapsed time tt and mask m.
  function automatic logic [4:0] expect_out(input int tt, input logic [3:0] m);
    int pos, ph;
    logic tk, fd, en;
    if (tt < 0) return 5'b1_00_0_0;
    pos = (tt / PER) % 4;
    ph  = tt % PER;
    tk  = (tt > 0) && (ph == 0);
    fd  = tk && (pos == 0);
    en  = (DEAD_EN && ph < DEAD_CYC) ? 1'b1 : m[pos];
    return {en, 2'(pos), tk, fd};
  endfunction

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {en_n, a, b, tick, frame_done};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s t=%0d: {en_n,a,b,tick,fd} got %b expected %b", tag, t, obs, exp);
    end
  endtask

  // Advance the model with the inputs present at the edge, then check just after it.
  task automatic step(input string tag);
    logic [3:0] m;
    m = blank_mask;
    if (!run)       t = -1;
    else if (t < 0) t = 0;
    else            t = t + 1;
    @(posedge clk);
    #1;
    check(tag, expect_out(t, m));
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 t = -1;
    check(tag, 5'b1_00_0_0);
    #1 rst = 1'b0;
  endtask

  task automatic wait_phase(input int target, input string tag);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (t >= 0 && t % (4 * PER) == target) found = 1'b1;
      else step(tag);
    end
    vectors++;
    assert (found)
    else begin
      miscompares++;
      $error("FAIL %s: phase %0d not reached within budget, got t=%0d", tag, target, t);
    end
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    blank_mask = 4'b0000;
    #1 check("reset_async", 5'b1_00_0_0);
    @(posedge clk);
    #1 check("reset_held", 5'b1_00_0_0);
    rst = 1'b0;

    step("idle");
    step("idle");

    run = 1'b1;
    for (int i = 0; i < 20; i++) step("scan");

    blank_mask = 4'b0100;
    for (int i = 0; i < 16; i++) step("mask_0100");
    blank_mask = 4'b0000;

    // Drop run exactly on the terminal count of position 01.
    wait_phase(2 * PER - 1, "seek_tc01");
    run = 1'b0;
    step("run_drop");
    step("run_idle");
    run = 1'b1;
    for (int i = 0; i < 6; i++) step("restart");

    // Reset pulse while position 11 is lit.
    wait_phase(3 * PER + DEAD_CYC, "seek_on11");
    async_reset("rst_mid_on");
    for (int i = 0; i < 6; i++) step("resume");

    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
      else step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DIV_MAX, default 49999: prescaler terminal count; each position dwells DIV_MAX+1 clk cycles.
REQ-002 Parameter DEAD_CYC, default 8: per-position blanking cycles; legal range 1..DIV_MAX-1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  1 = scan enabled, 0 = idle and blanked.
REQ-006 blank_mask  input  4  bit i = 1 keeps position i dark while selected.
REQ-007 en_n  output  1  active-low enable to downstream 2:4 decoder; 1 = all decoder outputs inactive.
REQ-008 a  output  1  select MSB (pos[1]).
REQ-009 b  output  1  select LSB (pos[0]).
REQ-010 tick  output  1  one-cycle pulse on each position advance.
REQ-011 frame_done  output  1  one-cycle pulse on wrap from position 3 to 0.

Function
REQ-012 All outputs shall be registered; each changes on the clk edge after its causing condition.
REQ-013 The FSM shall have states IDLE, DEAD and ON.
REQ-014 IDLE: en_n=1, pos=0, prescaler=0; run=1 moves to DEAD (ON when deadtime is compiled out).
REQ-015 DEAD: en_n=1; after DEAD_CYC cycles in DEAD, move to ON.
REQ-016 ON: en_n = blank_mask[pos]; otherwise 0.
REQ-017 The prescaler shall count 0..DIV_MAX in DEAD and ON, starting at 0 on entry from IDLE.
REQ-018 At prescaler==DIV_MAX: prescaler becomes 0, pos becomes (pos+1) mod 4, tick=1, state becomes DEAD (ON when deadtime is compiled out).
REQ-019 frame_done shall assert in the same cycle as tick when pos wraps from 3 to 0.
REQ-020 {a,b} shall equal pos in all states, so position i drives decoder output i low.
REQ-021 run=0 in any state: next cycle IDLE, en_n=1, pos=0, prescaler=0.
REQ-022 run=0 coinciding with a terminal count: run wins; no tick and no frame_done.
REQ-023 blank_mask changes shall take effect on the next clk edge and shall not alter timing or the pos sequence.
REQ-024 DIV_MAX=0 is illegal.

Reset
REQ-025 rst=1 shall immediately force state=IDLE, en_n=1, a=0, b=0, tick=0, frame_done=0, prescaler=0, dead counter=0, independent of clk.
REQ-026 Reset release mid-operation shall restart from IDLE; the scan resumes on the first edge with run=1.

Configuration
REQ-027 Macro SCAN_SEQ_DEADTIME_EN defined: the DEAD state and dead counter shall be present, with behaviour as REQ-015.
REQ-028 Macro SCAN_SEQ_DEADTIME_EN undefined: there shall be no DEAD state and no dead counter, and every DEAD transition shall go directly to ON; DEAD_CYC is ignored.

Structure
REQ-029 Package scan_pkg shall hold the state enum (IDLE, DEAD, ON) and the default DIV_MAX/DEAD_CYC constants.
REQ-030 Sub-module scan_prescaler shall contain the terminal-count counter with clear input and tc output; the FSM and output registers stay in scan_sequencer.

Verification (DIV_MAX=3, DEAD_CYC=1, macro defined unless noted)
REQ-031 Reset, then run=1 with blank_mask=0000 -> {a,b} follows 00,01,10,11,00; tick every 4 cycles; each position shows en_n=1 for 1 cycle, then 0 for 3; frame_done only on the 11->00 tick.
REQ-032 blank_mask=0100 -> en_n stays 1 throughout position {a,b}=10; the other positions are unchanged; the period remains 16 cycles.
REQ-033 run dropped at prescaler==3 in position 01 -> no tick; the next cycle gives en_n=1 and {a,b}=00; re-raising run restarts at position 00.
REQ-034 rst pulsed asynchronously mid-ON at position 11 -> en_n=1, {a,b}=00, tick=0 before the next clk edge.
REQ-035 Macro undefined -> en_n=0 for all 4 cycles of each position; sequence and tick timing identical to REQ-031.
